ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: fetch watchdog limit in cycles (8-bit range, 1..255).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 pc_i  input  32  current fetch address from PC register.
REQ-005 ce_i  input  1  PC register chip enable; 0 = no fetching.
REQ-006 flush_i  input  1  pipeline flush from CTRL.
REQ-007 stall_i  input  1  IF-stage stall from CTRL.
REQ-008 bus_req_o  output  1  instruction bus request.
REQ-009 bus_addr_o  output  32  instruction bus address.
REQ-010 bus_ack_i  input  1  bus completion strobe, single-cycle.
REQ-011 bus_rdata_i  input  32  read data, valid when bus_ack_i=1.
REQ-012 inst_o  output  32  fetched instruction.
REQ-013 inst_valid_o  output  1  inst_o holds a live instruction.
REQ-014 stallreq_o  output  1  stall request to CTRL.
REQ-015 fetch_err_o  output  1  one-cycle bus timeout pulse.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, KILL.
REQ-017 IDLE: ce_i=1, flush_i=0, stall_i=0 -> next edge: bus_req_o=1, bus_addr_o=pc_i, inst_valid_o=0, state WAIT; otherwise remain IDLE.
REQ-018 WAIT: bus_req_o and bus_addr_o SHALL stay constant until bus_ack_i=1.
REQ-019 stallreq_o SHALL be combinational: 1 in WAIT with bus_ack_i=0, 1 throughout KILL, 0 in IDLE.
REQ-020 WAIT with bus_ack_i=1, flush_i=0 -> next edge: inst_o=bus_rdata_i, inst_valid_o=1, bus_req_o=0, state IDLE.
REQ-021 WAIT with flush_i=1 (including same cycle as ack) -> data discarded, inst_valid_o=0; if ack present go IDLE, else go KILL with bus_req_o held.
REQ-022 KILL: on bus_ack_i=1 discard data, drop bus_req_o, go IDLE; flush_i in KILL has no further effect.
REQ-023 flush_i=1 in IDLE SHALL clear inst_valid_o next edge and issue no request that cycle.
REQ-024 inst_o SHALL hold its value until next capture; inst_valid_o SHALL hold through stall_i=1.
REQ-025 bus_ack_i in IDLE SHALL be ignored.
REQ-026 ce_i=0 SHALL block new requests only; an outstanding fetch completes normally.
REQ-027 Minimum back-to-back fetch spacing: request cycle, ack cycle, one IDLE cycle (3 cycles with zero-wait bus).

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, bus_req_o=0, bus_addr_o=0, inst_o=0, inst_valid_o=0, fetch_err_o=0, watchdog count=0, regardless of clk.
REQ-029 Reset during WAIT/KILL SHALL abandon the transaction; a later stray bus_ack_i in IDLE is ignored.
REQ-030 First request SHALL issue no earlier than the second rising edge after rst rises (ce_i gating).

Configuration
REQ-031 Macro IFETCH_TIMEOUT_EN defined: 8-bit counter clears on entry to WAIT, increments each WAIT/KILL cycle without ack; at count=TIMEOUT_CYCLES drop bus_req_o, inst_valid_o=0, pulse fetch_err_o one cycle, go IDLE.
REQ-032 Macro IFETCH_TIMEOUT_EN undefined: no counter, fetch_err_o tied 0, WAIT/KILL wait for ack indefinitely.

Verification
REQ-033 Zero-wait fetch: rst release, ce_i=1, pc_i=0xbfc00000, ack next cycle with 0x3c011234 -> bus_addr_o=0xbfc00000, inst_o=0x3c011234, inst_valid_o=1, stallreq_o=1 for exactly the request cycle.
REQ-034 Wait states: ack delayed 4 cycles -> bus_req_o/bus_addr_o stable 5 cycles, stallreq_o=1 for 4 cycles, 0 on ack cycle.
REQ-035 Flush mid-fetch: flush_i at cycle 2 of WAIT, ack at cycle 5 with 0xdeadbeef -> state KILL, stallreq_o=1 through ack, inst_valid_o=0, inst_o unchanged, next fetch uses new pc_i=0xbfc00380.
REQ-036 Stall hold: stall_i=1 for 3 cycles after capture -> no request, inst_o/inst_valid_o held, request issues the cycle after stall_i falls.
REQ-037 Async reset in WAIT: rst=0 mid-cycle -> bus_req_o=0 before next edge; stray ack afterwards produces no inst_valid_o.
REQ-038 With IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> bus_req_o drops after 8 cycles, fetch_err_o=1 exactly one cycle, state IDLE.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues one instruction-bus read per fetch,
// holds the request until the bus acknowledges, and discards data for
// fetches that were flushed while outstanding.
//
// Optional feature (macro IFETCH_TIMEOUT_EN): a watchdog aborts a fetch that
// has waited TIMEOUT_CYCLES cycles without an ack and pulses fetch_err_o.
// Without the macro fetch_err_o is tied low and the controller waits forever.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no fetch outstanding; launches a request when enabled
// WAIT  | request outstanding; ack data is captured into inst_o
// KILL  | request outstanding but flushed; ack data is dropped
module ifetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t state;
    logic   armed;
    logic   launch;
    logic   timeout;

    // armed keeps the first edge after reset release from launching a fetch,
    // even if ce_i is already high when rst rises.
    assign launch = armed && ce_i && !flush_i && !stall_i;

    // Stall the pipeline while a fetch is outstanding, except on the ack cycle
    // of a live fetch; a killed fetch stalls right through its ack.
    assign stallreq_o = ((state == WAIT) && !bus_ack_i) || (state == KILL);

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;

    // Timeout fires on the last waiting cycle so the request is dropped after
    // exactly TIMEOUT_CYCLES cycles on the bus.
    assign timeout = (state != IDLE) && !bus_ack_i && (wd_cnt == WD_LAST);

    // Watchdog: cleared when a fetch launches, counts unacked waiting cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= 8'd0;
        end else if ((state == IDLE) && launch) begin
            wd_cnt <= 8'd0;
        end else if ((state != IDLE) && !bus_ack_i) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Error strobe: one cycle, because a timeout always returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_err_o <= 1'b0;
        end else begin
            fetch_err_o <= timeout;
        end
    end
`else
    logic [7:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
    assign timeout               = 1'b0;
    assign fetch_err_o           = 1'b0;
`endif

    // Fetch FSM with registered bus and instruction outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            armed        <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_addr_o   <= 32'd0;
            inst_o       <= 32'd0;
            inst_valid_o <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        inst_valid_o <= 1'b0;
                    end else if (launch) begin
                        bus_req_o    <= 1'b1;
                        bus_addr_o   <= pc_i;
                        inst_valid_o <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        state     <= IDLE;
                        if (flush_i) begin
                            inst_valid_o <= 1'b0;
                        end else begin
                            inst_o       <= bus_rdata_i;
                            inst_valid_o <= 1'b1;
                        end
                    end else if (timeout) begin
                        bus_req_o    <= 1'b0;
                        inst_valid_o <= 1'b0;
                        state        <= IDLE;
                    end else if (flush_i) begin
                        inst_valid_o <= 1'b0;
                        state        <= KILL;
                    end
                end
                KILL: begin
                    if (bus_ack_i || timeout) begin
                        bus_req_o    <= 1'b0;
                        inst_valid_o <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    bus_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl. Captured instructions are checked by a
// scoreboard queue filled when ack data is driven for a live fetch.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        flush_i;
    logic        stall_i;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stallreq_o;
    logic        fetch_err_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        prev_valid = 1'b0;

    ifetch_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stallreq_o   (stallreq_o),
        .fetch_err_o  (fetch_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rising inst_valid_o must match the oldest expected word.
    always @(negedge clk) begin
        if (inst_valid_o && !prev_valid) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_pending observed=capture expected=none inst=%h", inst_o);
            end
            if (exp_q.size() > 0) check32("sb_inst", inst_o, exp_q.pop_front());
        end
        prev_valid = inst_valid_o;
    end

    initial begin
        rst = 1'b1; ce_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'd0; pc_i = 32'd0;

        // asynchronous reset before any clock edge
        #2 rst = 1'b0;
        #1;
        check1 ("rst_req",     bus_req_o,    1'b0);
        check32("rst_addr",    bus_addr_o,   32'd0);
        check32("rst_inst",    inst_o,       32'd0);
        check1 ("rst_valid",   inst_valid_o, 1'b0);
        check1 ("rst_stall",   stallreq_o,   1'b0);
        check1 ("rst_err",     fetch_err_o,  1'b0);
        tick(); tick();

        // zero-wait fetch, first request no earlier than second edge
        rst = 1'b1; ce_i = 1'b1; pc_i = 32'hbfc00000;
        tick();
        check1 ("first_edge_no_req", bus_req_o, 1'b0);
        tick();
        check1 ("zw_req",      bus_req_o,    1'b1);
        check32("zw_addr",     bus_addr_o,   32'hbfc00000);
        check1 ("zw_valid0",   inst_valid_o, 1'b0);
        check1 ("zw_stall_req_cycle", stallreq_o, 1'b1);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3c011234; exp_q.push_back(32'h3c011234);
        pc_i = 32'hbfc00004;
        #1;
        check1 ("zw_req_ack",  bus_req_o,    1'b1);
        check32("zw_addr_ack", bus_addr_o,   32'hbfc00000);
        check1 ("zw_stall_ack", stallreq_o,  1'b0);
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        #1;
        check1 ("zw_valid",    inst_valid_o, 1'b1);
        check32("zw_inst",     inst_o,       32'h3c011234);
        check1 ("zw_idle_req", bus_req_o,    1'b0);
        check1 ("zw_idle_stall", stallreq_o, 1'b0);
        tick();
        check1 ("b2b_req",     bus_req_o,    1'b1);
        check32("b2b_addr",    bus_addr_o,   32'hbfc00004);

        // four wait states, request held stable while pc_i moves
        pc_i = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            #1;
            check1 ("ws_req",   bus_req_o,  1'b1);
            check32("ws_addr",  bus_addr_o, 32'hbfc00004);
            check1 ("ws_stall", stallreq_o, 1'b1);
            tick();
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h8c220010; exp_q.push_back(32'h8c220010);
        ce_i = 1'b0;
        #1;
        check1 ("ws_req_ack",   bus_req_o,  1'b1);
        check32("ws_addr_ack",  bus_addr_o, 32'hbfc00004);
        check1 ("ws_stall_ack", stallreq_o, 1'b0);
        tick();
        bus_ack_i = 1'b0; ce_i = 1'b1; stall_i = 1'b1; pc_i = 32'hbfc00100;
        #1;
        check1 ("ws_valid",    inst_valid_o, 1'b1);
        check32("ws_inst",     inst_o,       32'h8c220010);

        // stall hold for three cycles, with a stray ack in IDLE
        for (int i = 0; i < 3; i++) begin
            bus_ack_i = (i == 1); bus_rdata_i = 32'hffffffff;
            tick();
            check1 ("stall_no_req", bus_req_o,    1'b0);
            check1 ("stall_valid",  inst_valid_o, 1'b1);
            check32("stall_inst",   inst_o,       32'h8c220010);
        end
        stall_i = 1'b0; bus_ack_i = 1'b0;
        #1;
        check1 ("stall_fall_req", bus_req_o, 1'b0);
        tick();
        check1 ("stall_after_req",  bus_req_o,  1'b1);
        check32("stall_after_addr", bus_addr_o, 32'hbfc00100);
        check1 ("stall_after_valid", inst_valid_o, 1'b0);

        // flush in WAIT cycle 2, ack in cycle 5
        tick();
        flush_i = 1'b1;
        #1;
        check1 ("fl_stall_w2", stallreq_o, 1'b1);
        tick();
        check1 ("fl_kill_req",   bus_req_o,    1'b1);
        check1 ("fl_kill_valid", inst_valid_o, 1'b0);
        check32("fl_kill_inst",  inst_o,       32'h8c220010);
        check1 ("fl_kill_stall", stallreq_o,   1'b1);
        tick();
        flush_i = 1'b0;
        #1;
        check1 ("fl_kill_stall4", stallreq_o, 1'b1);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hdeadbeef; pc_i = 32'hbfc00380;
        #1;
        check1 ("fl_stall_ack", stallreq_o, 1'b1);
        check1 ("fl_req_ack",   bus_req_o,  1'b1);
        tick();
        bus_ack_i = 1'b0;
        #1;
        check1 ("fl_idle_req",   bus_req_o,    1'b0);
        check1 ("fl_idle_valid", inst_valid_o, 1'b0);
        check32("fl_idle_inst",  inst_o,       32'h8c220010);
        check1 ("fl_idle_stall", stallreq_o,   1'b0);
        tick();
        check1 ("fl_next_req",   bus_req_o,  1'b1);
        check32("fl_next_addr",  bus_addr_o, 32'hbfc00380);

        // flush on the ack cycle drops the data; flush in IDLE blocks requests
        tick();
        bus_ack_i = 1'b1; flush_i = 1'b1; bus_rdata_i = 32'h11111111;
        #1;
        check1 ("flack_stall", stallreq_o, 1'b0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        check1 ("flack_req",   bus_req_o,    1'b0);
        check1 ("flack_valid", inst_valid_o, 1'b0);
        check32("flack_inst",  inst_o,       32'h8c220010);
        tick();
        check1 ("idle_flush_no_req", bus_req_o, 1'b0);
        flush_i = 1'b0; pc_i = 32'hbfc00400;
        tick();
        check1 ("pre_rst_req",  bus_req_o,  1'b1);
        check32("pre_rst_addr", bus_addr_o, 32'hbfc00400);

        // asynchronous reset in the middle of a WAIT cycle
        tick();
        #3 rst = 1'b0;
        #1;
        check1 ("arst_req",   bus_req_o,    1'b0);
        check32("arst_addr",  bus_addr_o,   32'd0);
        check32("arst_inst",  inst_o,       32'd0);
        check1 ("arst_valid", inst_valid_o, 1'b0);
        check1 ("arst_stall", stallreq_o,   1'b0);
        ce_i = 1'b0;
        tick();
        rst = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
        tick(); tick();
        check1 ("stray_valid", inst_valid_o, 1'b0);
        check32("stray_inst",  inst_o,       32'd0);
        check1 ("stray_req",   bus_req_o,    1'b0);
        bus_ack_i = 1'b0;

        // watchdog behaviour on a bus that never acks
        ce_i = 1'b1; pc_i = 32'hbfc00500;
        tick();
        ce_i = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            check1 ("wd_req_held", bus_req_o,   1'b1);
            check1 ("wd_no_err",   fetch_err_o, 1'b0);
            tick();
        end
        check1 ("wd_req_drop", bus_req_o,    1'b0);
        check1 ("wd_err",      fetch_err_o,  1'b1);
        check1 ("wd_valid",    inst_valid_o, 1'b0);
        check1 ("wd_stall",    stallreq_o,   1'b0);
        tick();
        check1 ("wd_err_once", fetch_err_o,  1'b0);
        check1 ("wd_idle_req", bus_req_o,    1'b0);
`else
        for (int k = 0; k < 20; k++) begin
            check1 ("nowd_req",   bus_req_o,   1'b1);
            check1 ("nowd_err",   fetch_err_o, 1'b0);
            check1 ("nowd_stall", stallreq_o,  1'b1);
            tick();
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'ha5a5a5a5; exp_q.push_back(32'ha5a5a5a5);
        #1;
        check1 ("nowd_stall_ack", stallreq_o, 1'b0);
        tick();
        bus_ack_i = 1'b0;
        check1 ("nowd_valid", inst_valid_o, 1'b1);
        check32("nowd_inst",  inst_o,       32'ha5a5a5a5);
        check1 ("nowd_err_end", fetch_err_o, 1'b0);
`endif

        tick(); tick();
        check32("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
